// File: rtl/rs232_frame_transmitter.sv
// RS-232 transmit path: a small byte FIFO feeding a start/data/parity/stop serializer.
// Optional CTS gating is applied only at frame start.
module rs232_frame_transmitter #(
  parameter int CLK_TICKS_PER_RS232_BIT = 434,
  parameter int DEFAULT_BYTE_LEN        = 8,
  parameter int DEFAULT_PARITY          = 1,
  parameter int DEFAULT_STOP_BITS       = 0,
  parameter int DEFAULT_FLOW_CONTROL    = 0,
  parameter int FIFO_DEPTH              = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_data_ready,
  output logic       tx_data_copied,
  output logic       tx_overflow,
  output logic       tx_busy,
  input  logic       cts,
  output logic       tx
);

  localparam int TICK_W     = $clog2(CLK_TICKS_PER_RS232_BIT);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int STOP_COUNT = (DEFAULT_STOP_BITS != 0) ? 2 : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Handshake: a 0->1 transition of tx_data_ready offers tx_data for one cycle;
  // the byte is accepted when the FIFO has room (or a pop frees a slot that cycle),
  // and acceptance is reported by a one-cycle tx_data_copied pulse.
  state_t            state, next_state;
  logic              ready_q;
  logic              ready_rise;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic [PTR_W-1:0]  wr_addr, rd_addr;
  logic              fifo_empty, fifo_full;
  logic              flow_ok, start_frame, fifo_pop, bypass, accept, fifo_we;
  logic [7:0]        load_byte;
  logic [TICK_W-1:0] tick;
  logic              tick_end;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              par;

  assign ready_rise = tx_data_ready & ~ready_q;
  assign wr_addr    = wr_ptr[PTR_W-1:0];
  assign rd_addr    = rd_ptr[PTR_W-1:0];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_addr == rd_addr);

  // An empty FIFO written while idle hands the byte straight to the shifter,
  // so the start bit appears on the same clock as the copy pulse.
  assign flow_ok     = (DEFAULT_FLOW_CONTROL == 0) || cts;
  assign start_frame = (state == IDLE) && flow_ok && (!fifo_empty || ready_rise);
  assign fifo_pop    = start_frame && !fifo_empty;
  assign bypass      = start_frame && fifo_empty;
  assign accept      = ready_rise && (!fifo_full || fifo_pop);
  assign fifo_we     = accept && !bypass;
  assign load_byte   = fifo_empty ? tx_data : mem[rd_addr];

  assign tick_end = (tick == TICK_W'(CLK_TICKS_PER_RS232_BIT - 1));
  assign tx_busy  = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q        <= 1'b0;
      tx_data_copied <= 1'b0;
      tx_overflow    <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
    end else begin
      ready_q        <= tx_data_ready;
      tx_data_copied <= accept;
      if (ready_rise && !accept) tx_overflow <= 1'b1;
      if (fifo_we)  wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (fifo_pop) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_we) mem[wr_addr] <= tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    tx         = 1'b1;
    case (state)
      IDLE: begin
        if (start_frame) next_state = START;
      end
      START: begin
        tx = 1'b0;
        if (tick_end) next_state = DATA;
      end
      DATA: begin
        tx = shift[0];
        if (tick_end && bit_idx == 3'(DEFAULT_BYTE_LEN - 1))
          next_state = (DEFAULT_PARITY != 0) ? PARITY : STOP;
      end
      PARITY: begin
        tx = (DEFAULT_PARITY == 2) ? ~par : par;
        if (tick_end) next_state = STOP;
      end
      STOP: begin
        tx = 1'b1;
        if (tick_end && bit_idx == 3'(STOP_COUNT - 1)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // bit_idx counts data bits in DATA and stop bits in STOP; it restarts on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par     <= 1'b0;
    end else if (state == IDLE) begin
      tick    <= '0;
      bit_idx <= '0;
      if (start_frame) begin
        shift <= load_byte;
        par   <= 1'b0;
      end
    end else if (tick_end) begin
      tick    <= '0;
      bit_idx <= (next_state != state) ? 3'd0 : bit_idx + 3'd1;
      if (state == DATA) begin
        shift <= {1'b0, shift[7:1]};
        par   <= par ^ shift[0];
      end
    end else begin
      tick <= tick + TICK_W'(1);
    end
  end

endmodule

// File: tb/tb_rs232_frame_transmitter.sv
// Directed bench for rs232_frame_transmitter: four differently configured instances
// share clock and reset; each line level is checked at the first and last clock of its bit.
module tb_rs232_frame_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [7:0] d_def, d_odd, d_fc, d_ovf;
  logic r_def, r_odd, r_fc, r_ovf;
  logic cts_def, cts_odd, cts_fc, cts_ovf;
  logic cp_def, cp_odd, cp_fc, cp_ovf;
  logic ov_def, ov_odd, ov_fc, ov_ovf;
  logic bz_def, bz_odd, bz_fc, bz_ovf;
  logic tx_def, tx_odd, tx_fc, tx_ovf;

  int total = 0;
  int bad   = 0;
  int copied_cnt [4] = '{0, 0, 0, 0};
  int busy_cnt   [4] = '{0, 0, 0, 0};
  int base_c, base_b;

  rs232_frame_transmitter u_def (
    .clk(clk), .rst(rst), .tx_data(d_def), .tx_data_ready(r_def),
    .tx_data_copied(cp_def), .tx_overflow(ov_def), .tx_busy(bz_def), .cts(cts_def), .tx(tx_def));

  rs232_frame_transmitter #(.DEFAULT_PARITY(2), .DEFAULT_STOP_BITS(1)) u_odd (
    .clk(clk), .rst(rst), .tx_data(d_odd), .tx_data_ready(r_odd),
    .tx_data_copied(cp_odd), .tx_overflow(ov_odd), .tx_busy(bz_odd), .cts(cts_odd), .tx(tx_odd));

  rs232_frame_transmitter #(.CLK_TICKS_PER_RS232_BIT(16), .DEFAULT_FLOW_CONTROL(1)) u_fc (
    .clk(clk), .rst(rst), .tx_data(d_fc), .tx_data_ready(r_fc),
    .tx_data_copied(cp_fc), .tx_overflow(ov_fc), .tx_busy(bz_fc), .cts(cts_fc), .tx(tx_fc));

  rs232_frame_transmitter #(.CLK_TICKS_PER_RS232_BIT(4), .FIFO_DEPTH(4),
                            .DEFAULT_FLOW_CONTROL(1)) u_ovf (
    .clk(clk), .rst(rst), .tx_data(d_ovf), .tx_data_ready(r_ovf),
    .tx_data_copied(cp_ovf), .tx_overflow(ov_ovf), .tx_busy(bz_ovf), .cts(cts_ovf), .tx(tx_ovf));

  always @(negedge clk) begin
    if (cp_def) copied_cnt[0]++;
    if (cp_odd) copied_cnt[1]++;
    if (cp_fc)  copied_cnt[2]++;
    if (cp_ovf) copied_cnt[3]++;
    if (bz_def) busy_cnt[0]++;
    if (bz_odd) busy_cnt[1]++;
    if (bz_fc)  busy_cnt[2]++;
    if (bz_ovf) busy_cnt[3]++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int i, input logic [7:0] b);
    case (i)
      0: begin d_def = b; r_def = 1'b1; end
      1: begin d_odd = b; r_odd = 1'b1; end
      2: begin d_fc  = b; r_fc  = 1'b1; end
      default: begin d_ovf = b; r_ovf = 1'b1; end
    endcase
  endtask

  task automatic drop(input int i);
    case (i)
      0: r_def = 1'b0;
      1: r_odd = 1'b0;
      2: r_fc  = 1'b0;
      default: r_ovf = 1'b0;
    endcase
  endtask

  function automatic logic tx_of(input int i);
    case (i)
      0: return tx_def;
      1: return tx_odd;
      2: return tx_fc;
      default: return tx_ovf;
    endcase
  endfunction

  function automatic logic busy_of(input int i);
    case (i)
      0: return bz_def;
      1: return bz_odd;
      2: return bz_fc;
      default: return bz_ovf;
    endcase
  endfunction

  // Called on the first clock of the start bit; levels are listed in line order, MSB first.
  // Returns on the clock right after the last stop bit.
  task automatic check_frame(input string tag, input int i, input logic [15:0] lv,
                             input int n, input int ticks);
    for (int j = 0; j < n; j++) begin
      chk($sformatf("%s_b%0d_first", tag, j), 32'(tx_of(i)), 32'(lv[n-1-j]));
      repeat (ticks - 1) @(negedge clk);
      chk($sformatf("%s_b%0d_last", tag, j), 32'(tx_of(i)), 32'(lv[n-1-j]));
      @(negedge clk);
    end
  endtask

  logic [7:0]  ovf_bytes  [5] = '{8'h07, 8'h22, 8'h33, 8'h80, 8'h55};
  logic [15:0] ovf_frames [4] = '{16'(11'b0_11100000_1_1), 16'(11'b0_01000100_0_1),
                                   16'(11'b0_11001100_0_1), 16'(11'b0_00000001_1_1)};

  initial begin
    rst = 1'b1;
    d_def = '0; d_odd = '0; d_fc = '0; d_ovf = '0;
    r_def = 1'b0; r_odd = 1'b0; r_fc = 1'b0; r_ovf = 1'b0;
    cts_def = 1'b0; cts_odd = 1'b0; cts_fc = 1'b0; cts_ovf = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx_def), 32'd1);
    chk("rst_busy", 32'(bz_def), 32'd0);
    chk("rst_copied", 32'(cp_def), 32'd0);
    chk("rst_overflow", 32'(ov_def), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single 0x53, ready held high for the whole frame, cts ignored at 0
    base_c = copied_cnt[0]; base_b = busy_cnt[0];
    put(0, 8'h53);
    @(negedge clk);
    chk("s53_copied_now", 32'(cp_def), 32'd1);
    chk("s53_busy_now", 32'(bz_def), 32'd1);
    check_frame("s53", 0, 16'(11'b0_11001010_0_1), 11, 434);
    chk("s53_idle_tx", 32'(tx_def), 32'd1);
    chk("s53_idle_busy", 32'(bz_def), 32'd0);
    chk("s53_copied_cnt", 32'(copied_cnt[0] - base_c), 32'd1);
    chk("s53_busy_cycles", 32'(busy_cnt[0] - base_b), 32'd4774);
    drop(0);
    repeat (2) @(negedge clk);

    // Back-to-back 0x53 then 0x8C (second byte queued during the first start bit)
    base_c = copied_cnt[0]; base_b = busy_cnt[0];
    put(0, 8'h53);
    fork
      begin
        @(negedge clk); drop(0);
        @(negedge clk); put(0, 8'h8C);
        @(negedge clk); drop(0);
      end
    join_none
    @(negedge clk);
    check_frame("b2b_53", 0, 16'(11'b0_11001010_0_1), 11, 434);
    chk("b2b_gap_tx", 32'(tx_def), 32'd1);
    chk("b2b_gap_busy", 32'(bz_def), 32'd1);
    @(negedge clk);
    check_frame("b2b_8c", 0, 16'(11'b0_00110001_1_1), 11, 434);
    chk("b2b_idle_busy", 32'(bz_def), 32'd0);
    chk("b2b_copied_cnt", 32'(copied_cnt[0] - base_c), 32'd2);
    chk("b2b_busy_cycles", 32'(busy_cnt[0] - base_b), 32'd9549);
    repeat (2) @(negedge clk);

    // 0x8C with odd parity and two stop bits
    base_c = copied_cnt[1]; base_b = busy_cnt[1];
    put(1, 8'h8C);
    @(negedge clk);
    drop(1);
    check_frame("odd_8c", 1, 16'(12'b0_00110001_0_11), 12, 434);
    chk("odd_idle_busy", 32'(busy_of(1)), 32'd0);
    chk("odd_copied_cnt", 32'(copied_cnt[1] - base_c), 32'd1);
    chk("odd_busy_cycles", 32'(busy_cnt[1] - base_b), 32'd5208);

    // Flow control: byte waits for cts, frame survives cts dropping mid-frame
    base_c = copied_cnt[2];
    put(2, 8'h5A);
    @(negedge clk);
    drop(2);
    repeat (30) @(negedge clk);
    chk("fc_hold_tx", 32'(tx_fc), 32'd1);
    chk("fc_hold_busy", 32'(bz_fc), 32'd1);
    chk("fc_copied_cnt", 32'(copied_cnt[2] - base_c), 32'd1);
    cts_fc = 1'b1;
    fork
      begin
        repeat (41) @(negedge clk);
        cts_fc = 1'b0;
      end
    join_none
    @(negedge clk);
    check_frame("fc_5a", 2, 16'(11'b0_01011010_0_1), 11, 16);
    chk("fc_idle_busy", 32'(bz_fc), 32'd0);
    chk("fc_idle_tx", 32'(tx_fc), 32'd1);

    // Overflow: five writes into a depth-4 FIFO held off by cts
    base_c = copied_cnt[3];
    for (int k = 0; k < 5; k++) begin
      put(3, ovf_bytes[k]);
      @(negedge clk);
      drop(3);
      @(negedge clk);
    end
    @(negedge clk);
    chk("ovf_copied_cnt", 32'(copied_cnt[3] - base_c), 32'd4);
    chk("ovf_flag", 32'(ov_ovf), 32'd1);
    chk("ovf_hold_tx", 32'(tx_ovf), 32'd1);
    chk("ovf_hold_busy", 32'(bz_ovf), 32'd1);
    cts_ovf = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check_frame($sformatf("ovf_f%0d", k), 3, ovf_frames[k], 11, 4);
      if (k < 3) begin
        chk($sformatf("ovf_gap%0d_busy", k), 32'(bz_ovf), 32'd1);
        @(negedge clk);
      end
    end
    chk("ovf_done_busy", 32'(bz_ovf), 32'd0);
    repeat (20) @(negedge clk);
    chk("ovf_no_fifth_tx", 32'(tx_ovf), 32'd1);
    chk("ovf_flag_sticky", 32'(ov_ovf), 32'd1);

    // Reset during data bit 3, then a clean 0xA5 frame
    put(0, 8'h53);
    @(negedge clk);
    chk("rmid_start", 32'(tx_def), 32'd0);
    drop(0);
    repeat (4 * 434 + 100) @(negedge clk);
    chk("rmid_bit3", 32'(tx_def), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rmid_tx", 32'(tx_def), 32'd1);
    chk("rmid_busy", 32'(bz_def), 32'd0);
    chk("rmid_overflow", 32'(ov_def), 32'd0);
    chk("rmid_ovf_cleared", 32'(ov_ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_tx", 32'(tx_def), 32'd1);
    put(0, 8'hA5);
    @(negedge clk);
    check_frame("post_a5", 0, 16'(11'b0_10100101_0_1), 11, 434);
    chk("post_idle_busy", 32'(bz_def), 32'd0);
    drop(0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
